// File: rtl/ifetch_unit.sv
// ifetch_unit: one-word-at-a-time instruction fetch between PC and imem.
// Optional build macro: IFETCH_ALIGN_CHECK_EN (misaligned-PC trap).
//
// Ports:
//   clk, rst          clock, async active-low reset
//   pc / pc_en        current PC in, advance strobe out
//   flush             redirect; npc holds target this cycle
//   imem_req_*        valid/ready read request (addr word aligned)
//   imem_resp_*       one response per accepted request
//   inst_valid/ready  handshake to decode
//   inst, inst_pc     buffered word and its address
//   inst_ale          misaligned-fetch flag
module ifetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_ale
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t state;
  logic   kill;
  logic   mis;
  logic   ale_q;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign mis = |pc[1:0];
`else
  assign mis = 1'b0;
`endif

  assign inst_ale = ale_q;

  // Gated by rst so the PC register never steps while held in reset.
  assign pc_en = rst &
    (flush | ((state == HOLD) & inst_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      ale_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // pc is being redirected on a flush edge; don't latch it.
          if (!flush) begin
            inst_pc <= pc;
            ale_q   <= mis;
            if (mis) begin
              inst       <= '0;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              imem_req_addr  <= {pc[ADDR_W-1:2], 2'b00};
              imem_req_valid <= 1'b1;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          // Request is never withdrawn; a flush only marks it dead.
          if (flush) kill <= 1'b1;
          if (imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (kill | flush) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              inst       <= imem_resp_data;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (flush | inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
